// File: rtl/axi_adc_jesd204_rx_deframer_if.sv
// Link-side beat stream and ADC-side sample stream of the JESD204 RX deframer.
// The deframer takes the slave modport; the link layer / ADC core pair takes master.
interface axi_adc_jesd204_rx_deframer_if #(
    parameter int NUM_LANES = 4
);
    logic                     rx_valid;
    logic [NUM_LANES*32-1:0]  rx_data;
    logic [3:0]               rx_sof;
    logic                     rx_ready;
    logic                     adc_valid;
    logic [NUM_LANES*32-1:0]  adc_data;

    modport master (
        output rx_valid, rx_data, rx_sof,
        input  rx_ready, adc_valid, adc_data
    );

    modport slave (
        input  rx_valid, rx_data, rx_sof,
        output rx_ready, adc_valid, adc_data
    );
endinterface

// File: rtl/axi_adc_jesd204_rx_deframer.sv
// JESD204 RX deframer: frame lock on rx_sof, octet realign, lane-major to channel-major samples.
// Optional offset-binary to two's-complement conversion when ADC_RX_DFMT_EN is defined.
module axi_adc_jesd204_rx_deframer #(
    parameter int NUM_LANES    = 4,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                                rx_clk,
    input  logic                                adc_rst,
    axi_adc_jesd204_rx_deframer_if.slave        bus,
    input  logic                                adc_dfmt_enable,
    input  logic                                adc_err_clr,
    output logic                                adc_locked,
    output logic [7:0]                          adc_sof_err_count
);

    localparam int DATA_PATH_WIDTH = 2 * NUM_LANES / NUM_CHANNELS;
    localparam int W               = NUM_LANES * 32;

    typedef enum logic {WAIT_SOF, LOCKED} state_t;

    state_t         state_q, state_d;
    logic           offset_q, offset_d;     // 1 selects a two-octet frame offset
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           ready_q, ready_d;
    logic [W-1:0]   prev_q, prev_d;
    logic [W-1:0]   s1_data_q, s1_data_d;
    logic           s1_valid_q, s1_valid_d;
    logic [W-1:0]   s2_data_q, s2_data_d;
    logic           s2_valid_q, s2_valid_d;

    logic           accept;
    logic           sof_mark, sof_ok, sof_off;
    logic           err_inc, emit, align_off;
    logic           dfmt_flip;
    logic [W-1:0]   aligned, deframed;

    assign accept = bus.rx_valid & ready_q;

    // Only the lowest set marker bit counts; odd octet positions are never legal frame starts.
    always_comb begin
        sof_mark = |bus.rx_sof;
        sof_ok   = 1'b0;
        sof_off  = 1'b0;
        if (bus.rx_sof[0]) begin
            sof_ok = 1'b1;
        end else if (bus.rx_sof[1]) begin
            sof_ok = 1'b0;
        end else if (bus.rx_sof[2]) begin
            sof_ok  = 1'b1;
            sof_off = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        err_inc   = 1'b0;
        emit      = 1'b0;
        align_off = offset_q;
        if (accept) begin
            case (state_q)
                WAIT_SOF: begin
                    if (sof_mark) begin
                        if (sof_ok) begin
                            state_d   = LOCKED;
                            offset_d  = sof_off;
                            align_off = sof_off;
                            emit      = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (sof_mark && !(sof_ok && (sof_off == offset_q))) begin
                        err_inc = 1'b1;
                        state_d = WAIT_SOF;
                    end else begin
                        emit = 1'b1;
                    end
                end
                default: state_d = WAIT_SOF;
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (adc_err_clr) begin
            err_cnt_d = 8'd0;
        end else if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_align
        assign aligned[32*l +: 32] = align_off
            ? {bus.rx_data[32*l +: 16], prev_q[32*l+16 +: 16]}
            : bus.rx_data[32*l +: 32];
    end

`ifdef ADC_RX_DFMT_EN
    assign dfmt_flip = adc_dfmt_enable;
`else
    logic unused_dfmt_enable;
    assign unused_dfmt_enable = adc_dfmt_enable;
    assign dfmt_flip          = 1'b0;
`endif

    // Each sample is the big-endian octet pair {2h, 2h+1} of its lane word.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        for (genvar s = 0; s < DATA_PATH_WIDTH; s++) begin : g_smp
            localparam int IDX  = c * DATA_PATH_WIDTH + s;
            localparam int LANE = IDX / 2;
            localparam int H    = s % 2;
            assign deframed[16*IDX +: 16] =
                {s1_data_q[32*LANE+16*H +: 8] ^ {dfmt_flip, 7'b0},
                 s1_data_q[32*LANE+16*H+8 +: 8]};
        end
    end

    always_comb begin
        ready_d    = 1'b1;
        prev_d     = accept ? bus.rx_data : prev_q;
        s1_data_d  = accept ? aligned : s1_data_q;
        s1_valid_d = accept & emit;
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? deframed : s2_data_q;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rx_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state_q    <= WAIT_SOF;
            offset_q   <= 1'b0;
            err_cnt_q  <= 8'd0;
            ready_q    <= 1'b0;
            prev_q     <= '0;
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            err_cnt_q  <= err_cnt_d;
            ready_q    <= ready_d;
            prev_q     <= prev_d;
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            s2_data_q  <= s2_data_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign bus.rx_ready      = ready_q;
    assign bus.adc_valid     = s2_valid_q;
    assign bus.adc_data      = s2_data_q;
    assign adc_locked        = (state_q == LOCKED);
    assign adc_sof_err_count = err_cnt_q;

endmodule

// File: tb/tb_axi_adc_jesd204_rx_deframer.sv
// Directed bench for the JESD204 RX deframer; inputs change and outputs are sampled on the falling edge.
module tb_axi_adc_jesd204_rx_deframer;

    logic rx_clk;
    logic adc_rst;
    logic adc_dfmt_enable;
    logic adc_err_clr;
    logic adc_locked;
    logic [7:0] adc_sof_err_count;

    int vectors;
    int miscompares;

    axi_adc_jesd204_rx_deframer_if #(.NUM_LANES(4)) bus_if ();

    axi_adc_jesd204_rx_deframer #(
        .NUM_LANES    (4),
        .NUM_CHANNELS (2)
    ) dut (
        .rx_clk            (rx_clk),
        .adc_rst           (adc_rst),
        .bus               (bus_if),
        .adc_dfmt_enable   (adc_dfmt_enable),
        .adc_err_clr       (adc_err_clr),
        .adc_locked        (adc_locked),
        .adc_sof_err_count (adc_sof_err_count)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One falling-edge-to-falling-edge slot with the given beat on the inputs.
    task automatic cycle(input logic v, input logic [3:0] sof, input logic [127:0] d);
        bus_if.rx_valid = v;
        bus_if.rx_sof   = sof;
        bus_if.rx_data  = d;
        @(negedge rx_clk);
    endtask

    task automatic do_reset();
        adc_rst = 1'b1;
        cycle(1'b0, 4'b0000, '0);
        check("rst_valid",  {127'b0, bus_if.adc_valid}, 128'd0);
        check("rst_locked", {127'b0, adc_locked},       128'd0);
        check("rst_count",  {120'b0, adc_sof_err_count}, 128'd0);
        check("rst_ready",  {127'b0, bus_if.rx_ready},  128'd0);
        adc_rst = 1'b0;
        cycle(1'b0, 4'b0000, '0);
        check("ready_up",   {127'b0, bus_if.rx_ready},  128'd1);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        adc_rst         = 1'b1;
        adc_dfmt_enable = 1'b0;
        adc_err_clr     = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_sof   = 4'b0000;
        bus_if.rx_data  = '0;
        @(negedge rx_clk);
        @(negedge rx_clk);
        do_reset();
        check("init_data",  bus_if.adc_data, 128'd0);

        // Lock at offset 0; lane words map straight into channel samples.
        cycle(1'b1, 4'b0001, 128'h00FFEEDD_CCBBAA99_88776655_44332211);
        check("lock0_locked", {127'b0, adc_locked}, 128'd1);
        check("lock0_lat1",   {127'b0, bus_if.adc_valid}, 128'd0);
        cycle(1'b0, 4'b0000, '0);
        check("lock0_valid",  {127'b0, bus_if.adc_valid}, 128'd1);
        check("lock0_data",   bus_if.adc_data, 128'hFF00DDEE_BBCC99AA_77885566_33441122);
        cycle(1'b0, 4'b0000, '0);
        check("gap_valid",    {127'b0, bus_if.adc_valid}, 128'd0);

        // Locked beat, then an off-position marker: earlier beat emits, offender does not.
        cycle(1'b1, 4'b0000, 128'h00000000_00000000_00000000_04030201);
        cycle(1'b1, 4'b0100, 128'h11111111_11111111_11111111_11111111);
        check("unlock_count",  {120'b0, adc_sof_err_count}, 128'd1);
        check("unlock_locked", {127'b0, adc_locked}, 128'd0);
        check("inflight_valid", {127'b0, bus_if.adc_valid}, 128'd1);
        check("inflight_data", bus_if.adc_data, 128'h00000000_00000000_00000000_03040102);
        cycle(1'b1, 4'b0010, 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A);
        check("offend_valid",  {127'b0, bus_if.adc_valid}, 128'd0);
        check("wait_err_count", {120'b0, adc_sof_err_count}, 128'd2);
        check("wait_locked",   {127'b0, adc_locked}, 128'd0);
        cycle(1'b0, 4'b0000, '0);
        check("wait_no_valid", {127'b0, bus_if.adc_valid}, 128'd0);

        // Mid-run reset clears previous-beat registers, then lock at offset 2.
        do_reset();
        cycle(1'b1, 4'b0100, 128'h00000000_00000000_00000000_DDCCBBAA);
        check("lock2_locked", {127'b0, adc_locked}, 128'd1);
        cycle(1'b1, 4'b0000, 128'h00000000_00000000_00000000_44332211);
        check("lock2_first_valid", {127'b0, bus_if.adc_valid}, 128'd1);
        check("lock2_first_data", bus_if.adc_data, 128'h00000000_00000000_00000000_AABB0000);
        cycle(1'b0, 4'b0000, '0);
        check("lock2_second_valid", {127'b0, bus_if.adc_valid}, 128'd1);
        check("lock2_second_data", bus_if.adc_data, 128'h00000000_00000000_00000000_1122CCDD);
        cycle(1'b1, 4'b0100, '0);
        check("lock2_match_locked", {127'b0, adc_locked}, 128'd1);
        check("lock2_match_count", {120'b0, adc_sof_err_count}, 128'd0);

        // 300 invalid markers saturate the count; clear wins over a simultaneous error.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 4'b0010, '0);
        end
        check("sat_count",  {120'b0, adc_sof_err_count}, 128'd255);
        check("sat_locked", {127'b0, adc_locked}, 128'd0);
        adc_err_clr = 1'b1;
        cycle(1'b1, 4'b1000, '0);
        adc_err_clr = 1'b0;
        check("clr_prio", {120'b0, adc_sof_err_count}, 128'd0);
        cycle(1'b1, 4'b1000, '0);
        check("bit3_invalid", {120'b0, adc_sof_err_count}, 128'd1);
        cycle(1'b1, 4'b0110, '0);
        check("bit1_lowest", {120'b0, adc_sof_err_count}, 128'd2);
        check("bit1_locked", {127'b0, adc_locked}, 128'd0);
        cycle(1'b0, 4'b0001, '0);
        check("novalid_ignored", {127'b0, adc_locked}, 128'd0);
        cycle(1'b1, 4'b1100, '0);
        check("bit2_lowest_locks", {127'b0, adc_locked}, 128'd1);

        // Data format conversion on samples 8000 / 7FFF.
        do_reset();
        adc_dfmt_enable = 1'b1;
        cycle(1'b1, 4'b0001, 128'h00000000_00000000_00000000_FF7F0080);
        cycle(1'b0, 4'b0000, '0);
        check("dfmt_valid", {127'b0, bus_if.adc_valid}, 128'd1);
`ifdef ADC_RX_DFMT_EN
        check("dfmt_data", bus_if.adc_data, 128'h80008000_80008000_80008000_FFFF0000);
`else
        check("dfmt_data", bus_if.adc_data, 128'h00000000_00000000_00000000_7FFF8000);
`endif
        adc_dfmt_enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
